// File: rtl/rsa_lsb_modexp_pkg.sv
// rtl/rsa_lsb_modexp_pkg.sv - shared constants and FSM state type for the modexp engine
package rsa_pkg;

    localparam int RSA_WIDTH  = 256;
    localparam int RSA_MCNT_W = $clog2(RSA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MUL,
        UPD
    } rsa_state_t;

endpackage

// File: rtl/rsa_lsb_modexp_modmul.sv
// rtl/rsa_lsb_modexp_modmul.sv - bit-serial interleaved x*y mod N, one multiplier bit per step, MSB first
module rsa_interleaved_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             step,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH+1:0] r_acc;

    logic [WIDTH+1:0] w_dbl;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_n;
    logic [WIDTH+1:0] w_sub1;
    logic [WIDTH+1:0] w_sub2;

    // With R < N and y < N, 2R + y < 3N, so two conditional subtractions suffice
    assign w_dbl  = r_acc << 1;
    assign w_sum  = w_dbl + (r_x[WIDTH-1] ? {2'b00, y} : '0);
    assign w_n    = {2'b00, N};
    assign w_sub1 = (w_sum  >= w_n) ? (w_sum  - w_n) : w_sum;
    assign w_sub2 = (w_sub1 >= w_n) ? (w_sub1 - w_n) : w_sub1;
    assign r      = r_acc[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x   <= '0;
            r_acc <= '0;
        end else if (clr) begin
            r_x   <= x;
            r_acc <= '0;
        end else if (step) begin
            r_x   <= r_x << 1;
            r_acc <= w_sub2;
        end
    end

endmodule

// File: rtl/rsa_lsb_modexp.sv
// rtl/rsa_lsb_modexp.sv - LSB-first square-and-multiply M^e mod N; RSA_MODEXP_EARLY_EXIT_EN stops after the top set exponent bit
module rsa_lsb_modexp
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] A,
    output logic             ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rsa_state_t       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sq;
    logic [WIDTH-1:0] r_ebits;
    logic [WIDTH-1:0] r_n;
    logic [CW-1:0]    r_bitcnt;
    logic [CW-1:0]    r_mcnt;

    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_sqr;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_sq_next;
    logic             w_last;
    logic             w_clr;
    logic             w_step;

    // Multipliers reload x on the same edge acc/sq update, so they see the next values
    assign w_acc_next = (r_state == UPD && r_ebits[0]) ? w_prod : r_acc;
    assign w_sq_next  = (r_state == UPD) ? w_sqr : r_sq;

`ifdef RSA_MODEXP_EARLY_EXIT_EN
    assign w_last = (r_bitcnt == CW'(WIDTH - 1)) || (r_ebits[WIDTH-1:1] == '0);
`else
    assign w_last = (r_bitcnt == CW'(WIDTH - 1));
`endif

    assign w_clr  = (r_state == LOAD) || (r_state == UPD && !w_last);
    assign w_step = (r_state == MUL);

    rsa_interleaved_modmul #(.WIDTH(WIDTH)) u_prod (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .step  (w_step),
        .x     (w_acc_next),
        .y     (r_sq),
        .N     (r_n),
        .r     (w_prod)
    );

    rsa_interleaved_modmul #(.WIDTH(WIDTH)) u_square (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .step  (w_step),
        .x     (w_sq_next),
        .y     (r_sq),
        .N     (r_n),
        .r     (w_sqr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_sq     <= '0;
            r_ebits  <= '0;
            r_n      <= '0;
            r_bitcnt <= '0;
            r_mcnt   <= '0;
            A        <= '0;
            ready    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // Operands land straight in the working registers: acc = 1, sq = M
                    if (start) begin
                        r_acc    <= WIDTH'(1);
                        r_sq     <= M;
                        r_ebits  <= e;
                        r_n      <= N;
                        r_bitcnt <= '0;
                        ready    <= 1'b0;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_mcnt  <= CW'(WIDTH - 1);
                    r_state <= MUL;
                end
                MUL: begin
                    if (r_mcnt == '0) begin
                        r_state <= UPD;
                    end else begin
                        r_mcnt <= r_mcnt - 1'b1;
                    end
                end
                UPD: begin
                    r_acc    <= w_acc_next;
                    r_sq     <= w_sq_next;
                    r_ebits  <= r_ebits >> 1;
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (w_last) begin
                        A       <= w_acc_next;
                        ready   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_mcnt  <= CW'(WIDTH - 1);
                        r_state <= MUL;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_lsb_modexp.sv
// tb/tb_rsa_lsb_modexp.sv - directed checks of rsa_lsb_modexp at WIDTH=16
module tb_rsa_lsb_modexp;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] M;
    logic [15:0] e;
    logic [15:0] N;
    logic [15:0] A;
    logic        ready;

    int checks = 0;
    int fails  = 0;

    rsa_lsb_modexp #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .M     (M),
        .e     (e),
        .N     (N),
        .A     (A),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edges counted from the sampling edge (as edge 1) through the edge where ready rises
    function automatic int exp_lat(input logic [15:0] ev);
        int k;
        k = 1;
        for (int i = 0; i < 16; i++) if (ev[i]) k = i + 1;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
        return 2 + k * 17;
`else
        return 2 + 16 * 17 + 0 * k;
`endif
    endfunction

    // mode 1: scramble inputs while busy; mode 2: pulse start while busy
    task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] ev,
                          input logic [15:0] n, input logic [15:0] exp_a, input int mode);
        logic [15:0] prev;
        int          n_e;
        prev  = A;
        M     = m;
        e     = ev;
        N     = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, 32'(ready), 32'd0);
        chk({tag, "_hold"}, 32'(A), 32'(prev));
        n_e = 1;
        while (!ready && n_e < 2000) begin
            if (mode == 1 && n_e == 20) begin
                M = 16'h1234;
                e = 16'hffff;
                N = 16'hfff1;
            end
            if (mode == 2) start = (n_e % 37 == 0);
            @(posedge clk);
            #1;
            n_e++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(n_e), 32'(exp_lat(ev)));
        chk({tag, "_A"}, 32'(A), 32'(exp_a));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        M     = '0;
        e     = '0;
        N     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_A", 32'(A), 32'd0);
        chk("reset_ready", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        run_op("m4e13", 16'd4, 16'd13, 16'd497, 16'd445, 0);
        @(negedge clk);
        run_op("carm", 16'd7, 16'd560, 16'd561, 16'd1, 0);
        run_op("b2b", 16'd2, 16'd10, 16'd1000, 16'd24, 0);
        @(negedge clk);
        run_op("e_zero", 16'd5, 16'd0, 16'd11, 16'd1, 0);
        @(negedge clk);
        run_op("m_zero", 16'd0, 16'd5, 16'd11, 16'd0, 0);
        @(negedge clk);
        run_op("in_chg", 16'd3, 16'd4, 16'd7, 16'd4, 1);
        @(negedge clk);
        run_op("st_ign", 16'd2, 16'd5, 16'd13, 16'd6, 2);
        @(negedge clk);
        run_op("n_max", 16'd65534, 16'd3, 16'd65535, 16'd65534, 0);
        @(negedge clk);
        run_op("p16", 16'd2, 16'd16, 16'd65521, 16'd15, 0);
        @(negedge clk);
        run_op("n_two", 16'd1, 16'd7, 16'd2, 16'd1, 0);

        // Abort mid-operation: reset must clear A and raise ready without a clock edge
        @(negedge clk);
        M     = 16'd3;
        e     = 16'd5;
        N     = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_A", 32'(A), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("post_rst", 16'd3, 16'd5, 16'd7, 16'd5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
